// File: rtl/jk_drive_seq.sv
// Command-driven j/k sequencer for a bank of master-slave JK flops, with shadow state tracking.
// Define JK_SEQ_CHECK_EN to add the q_fb input and sticky mismatch output.
module jk_drive_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] shadow_known
`ifdef JK_SEQ_CHECK_EN
    ,
    input  logic [WIDTH-1:0] q_fb,
    output logic             mismatch
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] j_d, k_d;
    logic [WIDTH-1:0] sh_d, kn_d;
    logic             busy_d, done_d;

    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        sh_d    = shadow;
        kn_d    = shadow_known;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = APPLY;
                    op_d    = cmd_op;
                    mask_d  = cmd_mask;
                    cnt_d   = (cmd_len == '0) ? CNT_W'(1) : cmd_len;
                    j_d     = {WIDTH{cmd_op[1]}} & cmd_mask;
                    k_d     = {WIDTH{cmd_op[0]}} & cmd_mask;
                end
            end
            APPLY: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Each APPLY edge is one clock seen by the downstream flops.
                unique case (op_q)
                    2'b01: begin
                        sh_d = shadow & ~mask_q;
                        kn_d = shadow_known | mask_q;
                    end
                    2'b10: begin
                        sh_d = shadow | mask_q;
                        kn_d = shadow_known | mask_q;
                    end
                    2'b11: sh_d = shadow ^ mask_q;
                    default: ;
                endcase
                if (cnt_q == CNT_W'(1)) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end else begin
                    j_d = {WIDTH{op_q[1]}} & mask_q;
                    k_d = {WIDTH{op_q[0]}} & mask_q;
                end
            end
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            j            <= '0;
            k            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            shadow       <= '0;
            shadow_known <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            j            <= j_d;
            k            <= k_d;
            busy         <= busy_d;
            done         <= done_d;
            shadow       <= sh_d;
            shadow_known <= kn_d;
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic fault;

    assign fault = (state_q == GAP) &&
                   (|((q_fb ^ shadow) & shadow_known));

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (fault) begin
            mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_drive_seq.sv
// Scoreboard bench for jk_drive_seq: commands push expected drive/shadow results,
// a negedge monitor pops and compares them when done pulses.
`timescale 1ns/1ps
module tb_jk_drive_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_mask = 4'h0;
    logic [7:0] cmd_len = 8'd0;
    logic [3:0] j, k, shadow, shadow_known;
    logic       busy, done;
    logic [3:0] m_sh = 4'h0;
    logic [3:0] m_kn = 4'h0;
`ifdef JK_SEQ_CHECK_EN
    logic [3:0] fault_bits = 4'h0;
    logic [3:0] q_fb;
    logic       mismatch;
    assign q_fb = m_sh ^ fault_bits;
`endif

    int checks = 0;
    int errors = 0;
    int apply_cnt = 0;

    typedef struct {
        logic [3:0] ej;
        logic [3:0] ek;
        int         len;
        logic [3:0] sh;
        logic [3:0] kn;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    jk_drive_seq #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_mask(cmd_mask),
        .cmd_len(cmd_len),
        .j(j),
        .k(k),
        .busy(busy),
        .done(done),
        .shadow(shadow),
        .shadow_known(shadow_known)
`ifdef JK_SEQ_CHECK_EN
        ,
        .q_fb(q_fb),
        .mismatch(mismatch)
`endif
    );

    // Model of the flop bank: applied once per apply cycle.
    task automatic push(input logic [1:0] op, input logic [3:0] mask,
                        input logic [7:0] len);
        exp_t e;
        e.len = (len == 8'd0) ? 1 : int'(len);
        e.ej  = op[1] ? mask : 4'h0;
        e.ek  = op[0] ? mask : 4'h0;
        for (int i = 0; i < e.len; i++) begin
            case (op)
                2'b01: begin m_sh = m_sh & ~mask; m_kn = m_kn | mask; end
                2'b10: begin m_sh = m_sh | mask;  m_kn = m_kn | mask; end
                2'b11: m_sh = m_sh ^ mask;
                default: ;
            endcase
        end
        e.sh = m_sh;
        e.kn = m_kn;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL apply_unexpected busy=%b", busy);
                end else begin
                    if (j !== sb[0].ej || k !== sb[0].ek) begin
                        errors++;
                        $display("FAIL apply_jk got j=%h k=%h want j=%h k=%h",
                                 j, k, sb[0].ej, sb[0].ek);
                    end
                    apply_cnt++;
                end
            end
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected done=%b", done);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (apply_cnt != e.len || shadow !== e.sh ||
                        shadow_known !== e.kn) begin
                        errors++;
                        $display("FAIL cmd_result got len=%0d sh=%h kn=%h want len=%0d sh=%h kn=%h",
                                 apply_cnt, shadow, shadow_known, e.len, e.sh, e.kn);
                    end
                    apply_cnt = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        sb.delete();
        apply_cnt = 0;
        m_sh = 4'h0;
        m_kn = 4'h0;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] mask,
                        input logic [7:0] len, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL ready_timeout ready=%b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_mask = mask;
        cmd_len = len;
        push(op, mask, len);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !cmd_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || !cmd_ready) begin
            errors++;
            $display("FAIL idle_timeout pending=%0d ready=%b want 0 1",
                     sb.size(), cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_mask = 4'hF;
        cmd_len = 8'd3;
        do_reset();
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, j, k, shadow, shadow_known} !== {3'b100, 16'h0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b busy=%b done=%b j=%h k=%h sh=%h kn=%h want 1 0 0 0 0 0 0",
                     cmd_ready, busy, done, j, k, shadow, shadow_known);
        end
`ifdef JK_SEQ_CHECK_EN
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL reset_mismatch got %b want 0", mismatch);
        end
`endif
    endtask

    task automatic test_reset_cmd();
        send(2'b01, 4'hF, 8'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (j !== 4'h0 || k !== 4'hF || done !== 1'b0) begin
            errors++;
            $display("FAIL rcmd_apply got j=%h k=%h done=%b want 0 f 0", j, k, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || j !== 4'h0 || k !== 4'h0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rcmd_gap got done=%b j=%h k=%h rdy=%b want 1 0 0 0",
                     done, j, k, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rcmd_idle got done=%b rdy=%b busy=%b want 0 1 0",
                     done, cmd_ready, busy);
        end
    endtask

    task automatic test_set();
        int n = 0;
        send(2'b10, 4'b0101, 8'd3, 1'b0);
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL set_ready_low got %0d cycles want 4", n);
        end
        wait_idle();
    endtask

    task automatic test_toggle();
        send(2'b11, 4'hF, 8'd3, 1'b0);
        wait_idle();
        send(2'b11, 4'hF, 8'd2, 1'b0);
        send(2'b11, 4'b0110, 8'd1, 1'b0);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        send(2'b01, 4'b0011, 8'd0, 1'b1);
        cmd_op = 2'b10;
        cmd_mask = 4'b1100;
        cmd_len = 8'd2;
        @(negedge clk);
        n = 1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b_accept got edge T+%0d want T+3", n);
        end
        push(2'b10, 4'b1100, 8'd2);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_long();
        send(2'b10, 4'b1000, 8'd255, 1'b0);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        send(2'b10, 4'hF, 8'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        apply_cnt = 0;
        m_sh = 4'h0;
        m_kn = 4'h0;
        @(negedge clk);
        checks++;
        if (j !== 4'h0 || k !== 4'h0 || busy !== 1'b0 || done !== 1'b0 ||
            cmd_ready !== 1'b1 || shadow_known !== 4'h0 || shadow !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset got j=%h k=%h busy=%b done=%b rdy=%b sh=%h kn=%h want 0 0 0 0 1 0 0",
                     j, k, busy, done, cmd_ready, shadow, shadow_known);
        end
        repeat (8) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL mid_reset_done got %0d pulses want 0", dn);
        end
    endtask

`ifdef JK_SEQ_CHECK_EN
    task automatic test_check();
        do_reset();
        fault_bits = 4'b0001;
        send(2'b10, 4'b0001, 8'd1, 1'b0);
        wait_idle();
        checks++;
        if (mismatch !== 1'b1) begin
            errors++;
            $display("FAIL chk_detect got %b want 1", mismatch);
        end
        fault_bits = 4'h0;
        send(2'b11, 4'b0010, 8'd1, 1'b0);
        wait_idle();
        checks++;
        if (mismatch !== 1'b1) begin
            errors++;
            $display("FAIL chk_sticky got %b want 1", mismatch);
        end
        do_reset();
        send(2'b10, 4'b0010, 8'd1, 1'b0);
        fault_bits = 4'b0001;
        wait_idle();
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL chk_unknown got %b want 0", mismatch);
        end
        fault_bits = 4'h0;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_cmd();
        test_set();
        test_toggle();
        test_back_to_back();
        test_long();
        test_reset_mid();
`ifdef JK_SEQ_CHECK_EN
        test_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
